// File: rtl/ann_layer_sequencer.sv
// Layer sequencer: fetches params, starts the shared neuron, packs M results.
// Define SEQ_TIMEOUT_EN to add a WAIT watchdog that raises err after TMO cycles.
module ann_layer_sequencer #(
  parameter  int DW  = 8,
  parameter  int N   = 10,
  parameter  int M   = 4,
  parameter  int TMO = 255,
  localparam int AW  = (M > 1) ? $clog2(M) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            hidden_layer,
  input  logic [DW*N-1:0] in_vec,
  output logic [AW-1:0]   p_addr,
  input  logic [DW*N-1:0] p_weight,
  input  logic [DW-1:0]   p_bias,
  output logic [DW*N-1:0] n_value,
  output logic [DW*N-1:0] n_weight,
  output logic [DW-1:0]   n_bias,
  output logic            n_start,
  output logic            n_hidden,
  input  logic [DW-1:0]   n_result,
  input  logic            n_ready,
  output logic [DW*M-1:0] out_vec,
  output logic            done,
  output logic            busy,
  output logic            err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START,
    GUARD, WAIT, STORE, DONE
  } state_t;

  state_t        st;
  logic [AW-1:0] j;
  logic          last_j;

  assign last_j = (j == AW'(M - 1));

`ifdef SEQ_TIMEOUT_EN
  localparam int CW =
    ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  logic [CW-1:0] wd;
  logic          err_q;
  assign err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO != 0);
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st       <= IDLE;
      j        <= '0;
      p_addr   <= '0;
      n_value  <= '0;
      n_weight <= '0;
      n_bias   <= '0;
      n_start  <= 1'b0;
      n_hidden <= 1'b0;
      out_vec  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd       <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      n_start <= 1'b0;
      done    <= 1'b0;
      unique case (st)
        IDLE: begin
          if (go) begin
            n_value  <= in_vec;
            n_hidden <= hidden_layer;
            out_vec  <= '0;
            j        <= '0;
            p_addr   <= '0;
            busy     <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            st       <= FETCH;
          end
        end
        FETCH: st <= LOAD;
        LOAD: begin
          n_weight <= p_weight;
          n_bias   <= p_bias;
          n_start  <= 1'b1;
          st       <= START;
        end
        START: st <= GUARD;
        // ready may still be high from the previous neuron here
        GUARD: begin
`ifdef SEQ_TIMEOUT_EN
          wd <= '0;
`endif
          st <= WAIT;
        end
        WAIT: begin
          if (n_ready) begin
            st <= STORE;
`ifdef SEQ_TIMEOUT_EN
          end else if (wd == CW'(TMO - 1)) begin
            err_q <= 1'b1;
            done  <= 1'b1;
            st    <= DONE;
          end else begin
            wd <= wd + 1'b1;
`endif
          end
        end
        STORE: begin
          out_vec[DW*j +: DW] <= n_result;
          if (last_j) begin
            done <= 1'b1;
            st   <= DONE;
          end else begin
            j      <= j + 1'b1;
            p_addr <= j + 1'b1;
            st     <= FETCH;
          end
        end
        DONE: begin
          busy <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule
